cheshire_uart_exit_mon: RTL

//  Harness-side UART receive monitor for simulation/emulation top levels; successor to the fixed

---
 rtl/cheshire_uart_exit_mon.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cheshire_uart_exit_mon.sv
// rtl/cheshire_uart_exit_mon.sv - UART receive monitor with byte FIFO and in-band exit decoder
module cheshire_uart_exit_mon #(
    parameter int unsigned DivWidth  = 16,
    parameter int unsigned DataBits  = 8,
    parameter bit          ParityEn  = 1'b0,
    parameter bit          ParityOdd = 1'b0,
    parameter int unsigned StopBits  = 1,
    parameter int unsigned FifoDepth = 16,
    parameter logic [7:0]  ExitMagic = 8'h04
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [DivWidth-1:0] clk_div_i,
    input  logic                uart_rx_i,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic [7:0]          byte_o,
    output logic                frame_err_o,
    output logic                parity_err_o,
    output logic                overflow_o,
    output logic                exit_valid_o,
    output logic [31:0]         exit_o
);

    localparam int unsigned AW = $clog2(FifoDepth);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic {EX_IDLE, EX_CODE} ex_state_e;

    rx_state_e             rx_state_q, rx_state_d;
    ex_state_e             ex_state_q, ex_state_d;
    logic                  rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [DivWidth-1:0]   div_q, div_d, cnt_q, cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0]   shreg_q, shreg_d;
    logic                  par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
    logic                  frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [7:0]            rx_byte_q, rx_byte_d;
    logic [1:0]            code_n_q, code_n_d;
    logic [31:0]           code_q, code_d, exit_q, exit_d;
    logic                  exit_valid_q, exit_valid_d, overflow_q, overflow_d;
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]            mem_q [FifoDepth];

    logic                  fell, stop_bad, par_calc, fifo_empty, fifo_full, pop, push_req, push_ok;
    logic [DivWidth-1:0]   div_eff;
    logic [7:0]            data_ext;

    assign div_eff  = (clk_div_i < DivWidth'(4)) ? DivWidth'(4) : clk_div_i;
    assign fell     = rx_prev_q & ~rx_s2_q;
    assign stop_bad = stop_bad_q | ~rx_s2_q;
    assign par_calc = (^shreg_q) ^ rx_s2_q;

    always_comb begin
        data_ext = '0;
        data_ext[DataBits-1:0] = shreg_q;
    end

    // Receive FSM: all timing derived from the divider latched at the start edge
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_s1_d      = uart_rx_i;
        rx_s2_d      = rx_s1_q;
        rx_prev_d    = rx_s2_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        rx_vld_d     = 1'b0;
        rx_byte_d    = rx_byte_q;
        if (rx_state_q != RX_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - DivWidth'(1);
        end else begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (fell) begin
                        div_d      = div_eff;
                        cnt_d      = (div_eff >> 1) - DivWidth'(1);
                        rx_state_d = RX_START;
                    end
                end
                RX_START: begin
                    cnt_d      = div_q - DivWidth'(1);
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    cnt_d   = div_q - DivWidth'(1);
                    shreg_d = {rx_s2_q, shreg_q[DataBits-1:1]};
                    if (bit_cnt_q == 4'(DataBits - 1)) begin
                        bit_cnt_d  = '0;
                        rx_state_d = ParityEn ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RX_PARITY: begin
                    cnt_d      = div_q - DivWidth'(1);
                    rx_state_d = RX_STOP;
                    if (par_calc != ParityOdd) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end
                end
                RX_STOP: begin
                    cnt_d = div_q - DivWidth'(1);
                    if (bit_cnt_q == 4'(StopBits - 1)) begin
                        rx_state_d = RX_IDLE;
                        if (stop_bad) begin
                            frame_err_d = 1'b1;
                        end else if (!par_bad_q) begin
                            rx_vld_d  = 1'b1;
                            rx_byte_d = data_ext;
                        end
                    end else begin
                        stop_bad_d = stop_bad;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
        if (!en_i) begin
            rx_state_d   = RX_IDLE;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            rx_vld_d     = 1'b0;
        end
    end

    // Exit parser swallows magic and code bytes; everything else heads to the FIFO
    always_comb begin
        ex_state_d   = ex_state_q;
        code_n_d     = code_n_q;
        code_d       = code_q;
        exit_d       = exit_q;
        exit_valid_d = exit_valid_q;
        push_req     = 1'b0;
        if (rx_vld_q) begin
            if (exit_valid_q) begin
                push_req = 1'b1;
            end else if (ex_state_q == EX_IDLE) begin
                if (rx_byte_q == ExitMagic) begin
                    ex_state_d = EX_CODE;
                    code_n_d   = 2'd0;
                end else begin
                    push_req = 1'b1;
                end
            end else begin
                code_d[{code_n_q, 3'b000} +: 8] = rx_byte_q;
                code_n_d = code_n_q + 2'd1;
                if (code_n_q == 2'd3) begin
                    exit_d       = {rx_byte_q, code_q[23:0]};
                    exit_valid_d = 1'b1;
                    ex_state_d   = EX_IDLE;
                end
            end
        end
        if ((frame_err_q || parity_err_q) && ex_state_q == EX_CODE) begin
            ex_state_d = EX_IDLE;
        end
    end

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = ~fifo_empty & byte_ready_i;
    assign push_ok    = push_req & (~fifo_full | pop);

    always_comb begin
        wptr_d     = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d     = rptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q | (push_req & ~push_ok);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= rx_byte_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state_q   <= RX_IDLE;
            ex_state_q   <= EX_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rx_vld_q     <= 1'b0;
            rx_byte_q    <= '0;
            code_n_q     <= '0;
            code_q       <= '0;
            exit_q       <= '0;
            exit_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            ex_state_q   <= ex_state_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            rx_prev_q    <= rx_prev_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            rx_vld_q     <= rx_vld_d;
            rx_byte_q    <= rx_byte_d;
            code_n_q     <= code_n_d;
            code_q       <= code_d;
            exit_q       <= exit_d;
            exit_valid_q <= exit_valid_d;
            overflow_q   <= overflow_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

    assign byte_valid_o = ~fifo_empty;
    assign byte_o       = fifo_empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overflow_o   = overflow_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_o       = exit_q;

endmodule
